// File: rtl/mc_control_unit.sv
// ---------------------------------------------------------------------------
// mc_control_unit
//   Moore-style main controller for the multi-cycle MIPS data path. Decodes
//   the opcode/funct held in the IR and sequences fetch, decode, execute,
//   memory and write-back. It also keeps a retired-instruction counter.
//
//   Optional feature macro: ADDI_EN
//     defined   -> ADDIEX/ADDIWB states exist, opcode 001000 executes addi
//     undefined -> opcode 001000 is treated as a NOP (DECODE -> FETCH)
//
// Parameters
//   CNT_WIDTH   width of the retired-instruction counter (wraps)
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-low reset
//   Opcode      in   IR[31:26]
//   Funct       in   IR[5:0]
//   Zero        in   ALU zero flag, used in BRANCH
//   PCen        out  PC write enable (Mealy in BRANCH: follows Zero)
//   IorD        out  memory address select 0=PC 1=ALUOut
//   MemWrite    out  memory write strobe
//   IRWrite     out  instruction register load
//   RegDst      out  write register select 0=rt 1=rd
//   MemtoReg    out  write data select 0=ALUOut 1=MDR
//   RegWrite    out  register file write enable
//   ALUSrcA     out  0=PC 1=A
//   PCsrc       out  0=ALU result 1=ALUOut
//   ALUSrcB     out  00=B 01=4 10=SignImm 11=SignImm<<2
//   ALUControl  out  010 add 110 sub 000 and 001 or 111 slt
//   State_o     out  current state encoding (debug)
//   Retired_o   out  completed instruction count
// ---------------------------------------------------------------------------
module mc_control_unit #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           Opcode,
  input  logic [5:0]           Funct,
  input  logic                 Zero,
  output logic                 PCen,
  output logic                 IorD,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic                 PCsrc,
  output logic [1:0]           ALUSrcB,
  output logic [2:0]           ALUControl,
  output logic [3:0]           State_o,
  output logic [CNT_WIDTH-1:0] Retired_o
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   retired_q, retired_d;

  // Ungated control values decoded from the state
  logic       pcen_c, iord_c, memwrite_c, irwrite_c, regdst_c;
  logic       memtoreg_c, regwrite_c, alusrca_c, pcsrc_c;
  logic [1:0] alusrcb_c;
  logic [2:0] aluctl_c;

  // Funct decode: ALU operation plus a legality flag (illegal -> NOP)
  logic       funct_legal;
  logic [2:0] funct_alu;

  always_comb begin
    funct_legal = 1'b1;
    funct_alu   = 3'b010;
    case (Funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default: begin
        funct_legal = 1'b0;
        funct_alu   = 3'b010;
      end
    endcase
  end

  always_comb begin
    state_d    = S_FETCH;
    pcen_c     = 1'b0;
    iord_c     = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    regdst_c   = 1'b0;
    memtoreg_c = 1'b0;
    regwrite_c = 1'b0;
    alusrca_c  = 1'b0;
    pcsrc_c    = 1'b0;
    alusrcb_c  = 2'b00;
    aluctl_c   = 3'b010;
    case (state_q)
      S_FETCH: begin
        irwrite_c = 1'b1;
        alusrcb_c = 2'b01;
        pcen_c    = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed here and parked in ALUOut
        alusrcb_c = 2'b11;
        if (Opcode == OP_LW || Opcode == OP_SW) begin
          state_d = S_MEMADR;
        end else if (Opcode == OP_RTYPE && funct_legal) begin
          state_d = S_EXECUTE;
        end else if (Opcode == OP_BEQ) begin
          state_d = S_BRANCH;
`ifdef ADDI_EN
        end else if (Opcode == OP_ADDI) begin
          state_d = S_ADDIEX;
`endif
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        state_d   = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord_c  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg_c = 1'b1;
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord_c     = 1'b1;
        memwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXECUTE: begin
        alusrca_c = 1'b1;
        aluctl_c  = funct_alu;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        regdst_c   = 1'b1;
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alusrca_c = 1'b1;
        aluctl_c  = 3'b110;
        pcsrc_c   = 1'b1;
        pcen_c    = Zero;   // the only Mealy output
        state_d   = S_FETCH;
      end
`ifdef ADDI_EN
      S_ADDIEX: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
`endif
      default: begin
        // Unreachable codes: all outputs zero, recover to FETCH
        aluctl_c = 3'b000;
        state_d  = S_FETCH;
      end
    endcase
  end

  // An instruction retires on every return to FETCH (NOPs included)
  always_comb begin
    retired_d = retired_q;
    if (state_d == S_FETCH && state_q != S_FETCH) begin
      retired_d = retired_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // FETCH asserts PCen/IRWrite, so every control is gated while reset is
  // low to keep the PC and memory untouched during reset.
  assign PCen       = reset & pcen_c;
  assign IorD       = reset & iord_c;
  assign MemWrite   = reset & memwrite_c;
  assign IRWrite    = reset & irwrite_c;
  assign RegDst     = reset & regdst_c;
  assign MemtoReg   = reset & memtoreg_c;
  assign RegWrite   = reset & regwrite_c;
  assign ALUSrcA    = reset & alusrca_c;
  assign PCsrc      = reset & pcsrc_c;
  assign ALUSrcB    = reset ? alusrcb_c : 2'b00;
  assign ALUControl = reset ? aluctl_c  : 3'b000;
  assign State_o    = state_q;
  assign Retired_o  = retired_q;

endmodule

// File: tb/tb_mc_control_unit.sv
module tb_mc_control_unit;

  logic        clk;
  logic        reset;
  logic [5:0]  Opcode;
  logic [5:0]  Funct;
  logic        Zero;

  logic        PCen, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCsrc;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUControl;
  logic [3:0]  State_o;
  logic [15:0] Retired_o;

  // Narrow-counter copy, used to exercise counter wrap in a short run
  logic        s_PCen, s_IorD, s_MemWrite, s_IRWrite, s_RegDst, s_MemtoReg, s_RegWrite, s_ALUSrcA, s_PCsrc;
  logic [1:0]  s_ALUSrcB;
  logic [2:0]  s_ALUControl;
  logic [3:0]  s_State_o;
  logic [3:0]  s_Retired_o;

  mc_control_unit dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .PCen(PCen), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .PCsrc(PCsrc), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .State_o(State_o), .Retired_o(Retired_o)
  );

  mc_control_unit #(.CNT_WIDTH(4)) dut_small (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .PCen(s_PCen), .IorD(s_IorD), .MemWrite(s_MemWrite), .IRWrite(s_IRWrite),
    .RegDst(s_RegDst), .MemtoReg(s_MemtoReg), .RegWrite(s_RegWrite), .ALUSrcA(s_ALUSrcA),
    .PCsrc(s_PCsrc), .ALUSrcB(s_ALUSrcB), .ALUControl(s_ALUControl),
    .State_o(s_State_o), .Retired_o(s_Retired_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [13:0] ctl;   // {PCen,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,PCsrc,ALUSrcB,ALUControl}
    logic [15:0] ret;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_cnt = 0;

  wire [13:0] ctl_obs = {PCen, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                         ALUSrcA, PCsrc, ALUSrcB, ALUControl};

  // Expected controls from the state table: bits built field by field
  function automatic logic [13:0] ctl_of(input logic [3:0] st, input logic z, input logic [2:0] alu);
    logic pcen, iord, mw, irw, rd, m2r, rw, sa, ps;
    logic [1:0] sb_;
    pcen = 0; iord = 0; mw = 0; irw = 0; rd = 0; m2r = 0; rw = 0; sa = 0; ps = 0; sb_ = 2'b00;
    case (st)
      4'd0:  begin pcen = 1; irw = 1; sb_ = 2'b01; end
      4'd1:  sb_ = 2'b11;
      4'd2:  begin sa = 1; sb_ = 2'b10; end
      4'd3:  iord = 1;
      4'd4:  begin m2r = 1; rw = 1; end
      4'd5:  begin iord = 1; mw = 1; end
      4'd6:  sa = 1;
      4'd7:  begin rd = 1; rw = 1; end
      4'd8:  begin sa = 1; ps = 1; pcen = z; end
      4'd9:  begin sa = 1; sb_ = 2'b10; end
      4'd10: rw = 1;
      default: ;
    endcase
    return {pcen, iord, mw, irw, rd, m2r, rw, sa, ps, sb_, alu};
  endfunction

  task automatic push(input logic [3:0] st, input logic z, input logic [2:0] alu);
    exp_t e;
    e.st  = st;
    e.ctl = ctl_of(st, z, alu);
    e.ret = exp_cnt[15:0];
    sb.push_back(e);
  endtask

  task automatic check_now(input string tag, input exp_t e);
    checks++;
    assert (State_o === e.st) else begin
      errors++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, State_o, e.st);
    end
    checks++;
    assert (ctl_obs === e.ctl) else begin
      errors++;
      $error("FAIL %s controls observed=%b expected=%b (state %0d)", tag, ctl_obs, e.ctl, e.st);
    end
    checks++;
    assert (Retired_o === e.ret) else begin
      errors++;
      $error("FAIL %s retired observed=%h expected=%h", tag, Retired_o, e.ret);
    end
    checks++;
    assert (s_Retired_o === e.ret[3:0]) else begin
      errors++;
      $error("FAIL %s retired4 observed=%h expected=%h", tag, s_Retired_o, e.ret[3:0]);
    end
  endtask

  // Drive one instruction's inputs and consume its expected states
  task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn, input logic z);
    exp_t e;
    Opcode = op; Funct = fn; Zero = z;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      #1;
      check_now(tag, e);
      @(posedge clk);
      @(negedge clk);
    end
    $display("txn %s op=%b funct=%b zero=%b retired=%0d", tag, op, fn, z, Retired_o);
  endtask

  initial begin
    exp_t e;
    reset = 1'b0; Opcode = 6'b0; Funct = 6'b0; Zero = 1'b0;

    // 1: reset held low for three cycles, all controls gated to zero
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e.st = 4'd0; e.ctl = 14'd0; e.ret = 16'd0;
      check_now("reset", e);
    end
    reset = 1'b1;

    // 2: R-type sub
    push(0, 0, 3'b010); push(1, 0, 3'b010); push(6, 0, 3'b110); push(7, 0, 3'b010);
    exp_cnt++;
    run("r_sub", 6'b000000, 6'b100010, 1'b0);

    // R-type and / or / slt / add
    push(0, 0, 3'b010); push(1, 0, 3'b010); push(6, 0, 3'b000); push(7, 0, 3'b010);
    exp_cnt++;
    run("r_and", 6'b000000, 6'b100100, 1'b0);
    push(0, 0, 3'b010); push(1, 0, 3'b010); push(6, 0, 3'b001); push(7, 0, 3'b010);
    exp_cnt++;
    run("r_or", 6'b000000, 6'b100101, 1'b0);
    push(0, 0, 3'b010); push(1, 0, 3'b010); push(6, 0, 3'b111); push(7, 0, 3'b010);
    exp_cnt++;
    run("r_slt", 6'b000000, 6'b101010, 1'b0);
    push(0, 0, 3'b010); push(1, 0, 3'b010); push(6, 0, 3'b010); push(7, 0, 3'b010);
    exp_cnt++;
    run("r_add", 6'b000000, 6'b100000, 1'b0);

    // 3: lw
    push(0, 0, 3'b010); push(1, 0, 3'b010); push(2, 0, 3'b010); push(3, 0, 3'b010); push(4, 0, 3'b010);
    exp_cnt++;
    run("lw", 6'b100011, 6'b000000, 1'b0);

    // sw
    push(0, 0, 3'b010); push(1, 0, 3'b010); push(2, 0, 3'b010); push(5, 0, 3'b010);
    exp_cnt++;
    run("sw", 6'b101011, 6'b000000, 1'b0);

    // 4: beq taken then not taken
    push(0, 1, 3'b010); push(1, 1, 3'b010); push(8, 1, 3'b110);
    exp_cnt++;
    run("beq_taken", 6'b000100, 6'b000000, 1'b1);
    push(0, 0, 3'b010); push(1, 0, 3'b010); push(8, 0, 3'b110);
    exp_cnt++;
    run("beq_not", 6'b000100, 6'b000000, 1'b0);

    // 5: addi
`ifdef ADDI_EN
    push(0, 0, 3'b010); push(1, 0, 3'b010); push(9, 0, 3'b010); push(10, 0, 3'b010);
`else
    push(0, 0, 3'b010); push(1, 0, 3'b010);
`endif
    exp_cnt++;
    run("addi", 6'b001000, 6'b000000, 1'b0);

    // 6: NOP opcode and illegal funct
    push(0, 0, 3'b010); push(1, 0, 3'b010);
    exp_cnt++;
    run("nop_op", 6'b111111, 6'b000000, 1'b0);
    push(0, 0, 3'b010); push(1, 0, 3'b010);
    exp_cnt++;
    run("nop_funct", 6'b000000, 6'b000000, 1'b0);

    // Reset asserted in the middle of sw (MEMWR)
    push(0, 0, 3'b010); push(1, 0, 3'b010); push(2, 0, 3'b010);
    run("sw_partial", 6'b101011, 6'b000000, 1'b0);
    e.st = 4'd5; e.ctl = ctl_of(4'd5, 1'b0, 3'b010); e.ret = exp_cnt[15:0];
    #1;
    check_now("memwr_before_reset", e);
    reset = 1'b0;
    #1;
    e.st = 4'd0; e.ctl = 14'd0; e.ret = 16'd0;
    check_now("memwr_reset", e);
    exp_cnt = 0;
    @(negedge clk);
    reset = 1'b1;

    // Counter wrap on the narrow instance: 17 NOPs pass 15 -> 0
    for (int i = 0; i < 17; i++) begin
      push(0, 0, 3'b010); push(1, 0, 3'b010);
      exp_cnt++;
      run("nop_wrap", 6'b111111, 6'b000000, 1'b0);
    end
    e.st = 4'd0; e.ctl = ctl_of(4'd0, 1'b0, 3'b010); e.ret = exp_cnt[15:0];
    #1;
    check_now("final", e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
